// File: rtl/apb_pkg.sv
// Shared constants and types for the APB register completer.
// Register map, FSM states and a byte-strobe merge helper.
package apb_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 32;
    localparam int SW_DEF = DW_DEF / 8;

    localparam logic [31:0] ID_DEF = 32'hA5B0_0001;

    localparam logic [7:0] ADDR_CTRL    = 8'h00;
    localparam logic [7:0] ADDR_STATUS  = 8'h04;
    localparam logic [7:0] ADDR_SCRATCH = 8'h08;
    localparam logic [7:0] ADDR_ID      = 8'h0C;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    // Replace only the byte lanes whose strobe is set.
    function automatic logic [31:0] strb_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                r[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/apb_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
// Both stages clear to 0 on reset.
module apb_sync2 (
    input  logic pclk,
    input  logic preset,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_q;

    // Shift the async level through two pclk flops.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= d;
            r_q    <= r_meta;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/apb_reg_slave.sv
// APB completer with programmable wait states and a small register file.
// CTRL drives o_hw_ctl; STATUS reports a synchronized HW status and its edge.
module apb_reg_slave
    import apb_pkg::*;
#(
    parameter int              AW          = AW_DEF,
    parameter int              DW          = DW_DEF,
    parameter int              SW          = DW / 8,
    parameter int              WAIT_CYCLES = 1,
    parameter logic [DW-1:0]   ID_VALUE    = ID_DEF
) (
    input  logic          pclk,
    input  logic          preset,
    input  logic [AW-1:0] i_paddr,
    input  logic          i_pwrite,
    input  logic          i_psel,
    input  logic          i_penable,
    input  logic [DW-1:0] i_pwdata,
    input  logic [SW-1:0] i_pstrb,
    output logic [DW-1:0] o_prdata,
    output logic          o_pslverr,
    output logic          o_pready,
    output logic          o_hw_ctl,
    input  logic          i_hw_sts
);

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    apb_state_e    r_state;
    logic [3:0]    r_wcnt;
    logic          r_ctrl;
    logic [DW-1:0] r_scratch;
    logic          r_sts_d;
    logic          r_sts_edge;

    logic          w_setup;
    logic          w_ready;
    logic          w_aligned;
    logic          w_in_range;
    logic          w_hit_ctrl;
    logic          w_hit_status;
    logic          w_hit_scratch;
    logic          w_hit_id;
    logic          w_err;
    logic          w_commit;
    logic          w_sts_sync;
    logic          w_sts_rise;
    logic          w_sts_clr;
    logic [DW-1:0] w_rdata;

    apb_sync2 u_sync (
        .pclk   (pclk),
        .preset (preset),
        .d      (i_hw_sts),
        .q      (w_sts_sync)
    );

    // A setup phase is accepted whenever no access is in flight; SETUP is the
    // state right after a completion, where a back-to-back setup may arrive.
    assign w_setup = (r_state != ACCESS) & i_psel & ~i_penable;
    assign w_ready = (r_state == ACCESS) & i_psel & i_penable
                   & (r_wcnt == 4'd0);

    assign w_aligned     = (i_paddr[1:0] == 2'b00);
    assign w_in_range    = (i_paddr <= AW'(ADDR_ID));
    assign w_hit_ctrl    = (i_paddr == AW'(ADDR_CTRL));
    assign w_hit_status  = (i_paddr == AW'(ADDR_STATUS));
    assign w_hit_scratch = (i_paddr == AW'(ADDR_SCRATCH));
    assign w_hit_id      = (i_paddr == AW'(ADDR_ID));

    assign w_err    = ~w_aligned | ~w_in_range | (i_pwrite & w_hit_id);
    assign w_commit = w_ready & i_pwrite & ~w_err;

    assign w_sts_rise = w_sts_sync & ~r_sts_d;
    assign w_sts_clr  = w_commit & w_hit_status & i_pwdata[1] & i_pstrb[0];

    // Transfer FSM and wait-state counter.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state <= IDLE;
            r_wcnt  <= 4'd0;
        end else begin
            unique case (r_state)
                IDLE, SETUP: begin
                    if (w_setup) begin
                        r_wcnt  <= WAIT_LD;
                        r_state <= ACCESS;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ACCESS: begin
                    if (!i_psel) begin
                        r_state <= IDLE;
                    end else if (w_ready) begin
                        r_state <= SETUP;
                    end else if (r_wcnt != 4'd0) begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // CTRL register; its bit drives the HW control output directly.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_ctrl <= 1'b0;
        end else if (w_commit & w_hit_ctrl & i_pstrb[0]) begin
            r_ctrl <= i_pwdata[0];
        end
    end

    // SCRATCH register with per-byte write strobes.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_scratch <= '0;
        end else if (w_commit & w_hit_scratch) begin
            r_scratch <= strb_merge(r_scratch, i_pwdata, i_pstrb);
        end
    end

    // Sticky status edge: a new rising edge beats a same-cycle W1C clear.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_sts_d    <= 1'b0;
            r_sts_edge <= 1'b0;
        end else begin
            r_sts_d    <= w_sts_sync;
            r_sts_edge <= w_sts_rise | (r_sts_edge & ~w_sts_clr);
        end
    end

    // Read data mux; misaligned or unmapped addresses fall to zero.
    always_comb begin
        w_rdata = '0;
        unique case (1'b1)
            w_hit_ctrl:    w_rdata = {{(DW-1){1'b0}}, r_ctrl};
            w_hit_status:  w_rdata = {{(DW-2){1'b0}}, r_sts_edge, w_sts_sync};
            w_hit_scratch: w_rdata = r_scratch;
            w_hit_id:      w_rdata = ID_VALUE;
            default:       w_rdata = '0;
        endcase
    end

    assign o_pready  = w_ready;
    assign o_pslverr = w_ready & w_err;
    assign o_prdata  = (w_ready & ~i_pwrite & ~w_err) ? w_rdata : '0;
    assign o_hw_ctl  = r_ctrl;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Scoreboard bench for apb_reg_slave at WAIT_CYCLES = 1, 3 and 0.
// Driver queues expected responses; a negedge monitor checks each pready.
module tb_apb_reg_slave;

    logic        pclk = 1'b0;
    logic        preset;
    logic [7:0]  paddr;
    logic        pwrite;
    logic        penable;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        hw_sts;
    logic [2:0]  psel;

    logic [31:0] prdata  [3];
    logic        pslverr [3];
    logic        pready  [3];
    logic        hw_ctl  [3];

    typedef struct {
        int          inst;
        logic [7:0]  addr;
        logic [31:0] rdata;
        logic        err;
        int          waits;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   acc_cnt [3];
    int   waits_of [3] = '{1, 3, 0};

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc++;

    apb_reg_slave #(.WAIT_CYCLES(1)) u_w1 (
        .pclk(pclk), .preset(preset), .i_paddr(paddr), .i_pwrite(pwrite),
        .i_psel(psel[0]), .i_penable(penable), .i_pwdata(pwdata),
        .i_pstrb(pstrb), .o_prdata(prdata[0]), .o_pslverr(pslverr[0]),
        .o_pready(pready[0]), .o_hw_ctl(hw_ctl[0]), .i_hw_sts(hw_sts)
    );

    apb_reg_slave #(.WAIT_CYCLES(3)) u_w3 (
        .pclk(pclk), .preset(preset), .i_paddr(paddr), .i_pwrite(pwrite),
        .i_psel(psel[1]), .i_penable(penable), .i_pwdata(pwdata),
        .i_pstrb(pstrb), .o_prdata(prdata[1]), .o_pslverr(pslverr[1]),
        .o_pready(pready[1]), .o_hw_ctl(hw_ctl[1]), .i_hw_sts(hw_sts)
    );

    apb_reg_slave #(.WAIT_CYCLES(0)) u_w0 (
        .pclk(pclk), .preset(preset), .i_paddr(paddr), .i_pwrite(pwrite),
        .i_psel(psel[2]), .i_penable(penable), .i_pwdata(pwdata),
        .i_pstrb(pstrb), .o_prdata(prdata[2]), .o_pslverr(pslverr[2]),
        .o_pready(pready[2]), .o_hw_ctl(hw_ctl[2]), .i_hw_sts(hw_sts)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every pready consumes one scoreboard entry.
    always @(negedge pclk) begin
        for (int i = 0; i < 3; i++) begin
            if (pready[i] === 1'b1) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pready inst=%0d got 1 expected 0", i);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check($sformatf("inst a=%h", e.addr), 32'(i), 32'(e.inst));
                    check($sformatf("prdata[%0d] a=%h", i, e.addr),
                          prdata[i], e.rdata);
                    check($sformatf("pslverr[%0d] a=%h", i, e.addr),
                          32'(pslverr[i]), 32'(e.err));
                    check($sformatf("waits[%0d] a=%h", i, e.addr),
                          32'(acc_cnt[i]), 32'(e.waits));
                end
                acc_cnt[i] = 0;
            end else if (psel[i] && penable) begin
                acc_cnt[i]++;
            end else if (!psel[i]) begin
                acc_cnt[i] = 0;
            end
        end
    end

    // Runs one transfer; starts just after a posedge, returns just after
    // the completing edge with the bus still selected.
    task automatic xfer(input int inst, input logic wr, input logic [7:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input logic set_sts = 1'b0);
        exp_t e;
        bit   done;
        e.inst  = inst;
        e.addr  = addr;
        e.rdata = wr ? 32'h0 : exp_rd;
        e.err   = exp_err;
        e.waits = waits_of[inst];
        q.push_back(e);
        psel       = '0;
        psel[inst] = 1'b1;
        penable    = 1'b0;
        paddr      = addr;
        pwrite     = wr;
        pwdata     = data;
        pstrb      = strb;
        if (set_sts) hw_sts = 1'b1;
        @(posedge pclk);
        #1 penable = 1'b1;
        done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge pclk);
            if (pready[inst] === 1'b1) begin
                done = 1;
            end else begin
                @(posedge pclk);
                #1;
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout inst=%0d a=%h got no pready expected pready", inst, addr);
            void'(q.pop_back());
        end
        @(posedge pclk);
        #1;
    endtask

    task automatic idle(input int n);
        psel    = '0;
        penable = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic rd(input int inst, input logic [7:0] addr,
                      input logic [31:0] exp_rd, input logic exp_err);
        xfer(inst, 1'b0, addr, 32'h0, 4'h0, exp_rd, exp_err);
        idle(1);
    endtask

    task automatic wr(input int inst, input logic [7:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      input logic exp_err);
        xfer(inst, 1'b1, addr, data, strb, 32'h0, exp_err);
        idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        preset  = 1'b1;
        psel    = '0;
        penable = 1'b0;
        paddr   = '0;
        pwrite  = 1'b0;
        pwdata  = '0;
        pstrb   = '0;
        hw_sts  = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_prdata[%0d]", i), prdata[i], 32'h0);
            check($sformatf("rst_pslverr[%0d]", i), 32'(pslverr[i]), 32'h0);
            check($sformatf("rst_pready[%0d]", i), 32'(pready[i]), 32'h0);
            check($sformatf("rst_hw_ctl[%0d]", i), 32'(hw_ctl[i]), 32'h0);
        end
        preset = 1'b0;
        idle(1);

        wr(0, 8'h08, 32'hDEADBEEF, 4'hF, 1'b0);
        rd(0, 8'h08, 32'hDEADBEEF, 1'b0);
        wr(0, 8'h08, 32'h11223344, 4'b0101, 1'b0);
        rd(0, 8'h08, 32'hDE22BE44, 1'b0);
        wr(0, 8'h08, 32'h00000000, 4'h0, 1'b0);
        rd(0, 8'h08, 32'hDE22BE44, 1'b0);

        check("hw_ctl_pre", 32'(hw_ctl[0]), 32'h0);
        xfer(0, 1'b1, 8'h00, 32'h1, 4'h1, 32'h0, 1'b0);
        check("hw_ctl_post", 32'(hw_ctl[0]), 32'h1);
        idle(1);
        rd(0, 8'h00, 32'h1, 1'b0);
        rd(0, 8'h0C, 32'hA5B00001, 1'b0);
        wr(0, 8'h0C, 32'h12345678, 4'hF, 1'b1);
        rd(0, 8'h0C, 32'hA5B00001, 1'b0);
        rd(0, 8'h10, 32'h0, 1'b1);
        rd(0, 8'h02, 32'h0, 1'b1);
        wr(0, 8'h09, 32'hFFFFFFFF, 4'hF, 1'b1);
        rd(0, 8'h08, 32'hDE22BE44, 1'b0);

        hw_sts = 1'b1;
        idle(4);
        rd(0, 8'h04, 32'h3, 1'b0);
        wr(0, 8'h04, 32'h2, 4'hF, 1'b0);
        rd(0, 8'h04, 32'h1, 1'b0);
        hw_sts = 1'b0;
        idle(4);
        rd(0, 8'h04, 32'h0, 1'b0);
        xfer(0, 1'b1, 8'h04, 32'h2, 4'h1, 32'h0, 1'b0, 1'b1);
        idle(1);
        rd(0, 8'h04, 32'h3, 1'b0);

        wr(1, 8'h08, 32'h0BADF00D, 4'hF, 1'b0);
        rd(1, 8'h08, 32'h0BADF00D, 1'b0);
        psel    = 3'b010;
        penable = 1'b0;
        paddr   = 8'h08;
        pwrite  = 1'b1;
        pwdata  = 32'hFFFFFFFF;
        pstrb   = 4'hF;
        @(posedge pclk);
        #1 penable = 1'b1;
        @(posedge pclk);
        #1;
        check("abort_pready_wait", 32'(pready[1]), 32'h0);
        psel    = '0;
        penable = 1'b0;
        #1;
        check("abort_pready_drop", 32'(pready[1]), 32'h0);
        idle(1);
        rd(1, 8'h08, 32'h0BADF00D, 1'b0);

        wr(1, 8'h00, 32'h1, 4'h1, 1'b0);
        check("hw_ctl1_set", 32'(hw_ctl[1]), 32'h1);
        psel    = 3'b010;
        penable = 1'b0;
        paddr   = 8'h0C;
        pwrite  = 1'b0;
        @(posedge pclk);
        #1 penable = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        check("pre_rst_pready", 32'(pready[1]), 32'h1);
        check("pre_rst_prdata", prdata[1], 32'hA5B00001);
        preset = 1'b1;
        #1;
        check("mid_rst_prdata", prdata[1], 32'h0);
        check("mid_rst_pslverr", 32'(pslverr[1]), 32'h0);
        check("mid_rst_pready", 32'(pready[1]), 32'h0);
        check("mid_rst_hw_ctl", 32'(hw_ctl[1]), 32'h0);
        psel    = '0;
        penable = 1'b0;
        @(posedge pclk);
        #1 preset = 1'b0;
        idle(1);
        rd(1, 8'h00, 32'h0, 1'b0);
        rd(1, 8'h08, 32'h0, 1'b0);

        t0 = cyc;
        xfer(2, 1'b1, 8'h08, 32'h000000AA, 4'b0001, 32'h0, 1'b0);
        xfer(2, 1'b1, 8'h08, 32'h0000BB00, 4'b0010, 32'h0, 1'b0);
        xfer(2, 1'b1, 8'h00, 32'h00000001, 4'b0001, 32'h0, 1'b0);
        xfer(2, 1'b0, 8'h08, 32'h0, 4'h0, 32'h0000BBAA, 1'b0);
        xfer(2, 1'b0, 8'h00, 32'h0, 4'h0, 32'h00000001, 1'b0);
        check("b2b_cycles", 32'(cyc - t0), 32'd10);
        idle(2);
        check("b2b_hw_ctl", 32'(hw_ctl[2]), 32'h1);
        check("scoreboard_left", 32'(q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
